// File: rtl/v_lsu_seq_pkg.sv
// Shared constants, state encoding and beat arithmetic for the vector LSU sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package v_lsu_seq_pkg;

  localparam int DEF_VLMAX         = 32;
  localparam int DEF_DATAMEM_BITS  = 14;
  localparam int DEF_DATAMEM_WIDTH = 32;

  // datamem word address fields: [DATAMEM_BITS-1] region, [..:ROW_LSB] row, [BANK_MSB:BANK_LSB] bank
  localparam int BANK_LSB  = 0;
  localparam int BANK_MSB  = 1;
  localparam int ROW_LSB   = 2;
  localparam int NUM_BANKS = 4;

  localparam int VL_W   = 6;  // element count width
  localparam int BEAT_W = 5;  // beat counter width, covers ceil((3+63)/4)
  localparam int IDX_W  = 7;  // signed element index width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } lsu_state_e;

  // Number of bank-parallel beats touched by a request: ceil((off + vl) / 4).
  function automatic logic [BEAT_W-1:0] beat_count(input logic [1:0] off,
                                                   input logic [VL_W-1:0] vl);
    logic [6:0] sum;
    sum = {5'd0, off} + {1'b0, vl} + 7'd3;
    return sum[6:2];
  endfunction

endpackage

// File: rtl/v_lsu_seq_lanemask.sv
// Active-bank mask for one beat: bank b is live when off <= 4*beat+b < off+vl.
// Latency: combinational.
// Backpressure: none.
// Ports: off (bank offset of base), vl (element count), beat (beat index) -> mask (one bit per bank).
module v_lsu_seq_lanemask
  import v_lsu_seq_pkg::*;
(
  input  logic [1:0]           off,
  input  logic [VL_W-1:0]      vl,
  input  logic [BEAT_W-1:0]    beat,
  output logic [NUM_BANKS-1:0] mask
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic [7:0] base;

  always_comb begin
    lo   = {6'd0, off};
    hi   = lo + {2'd0, vl};
    base = {1'b0, beat, 2'b00};
    mask = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      mask[b] = ((base + 8'(b)) >= lo) && ((base + 8'(b)) < hi);
    end
  end

endmodule

// File: rtl/v_lsu_seq.sv
// Unit-stride vector load/store sequencer driving the four-bank datamem core port, one beat per cycle.
// Latency: first beat 1 cycle after accept; load data 1 cycle after issue; done 1 cycle after last beat.
// Backpressure: req_ready only in IDLE; store beats stall while st_valid is low (address held, no writes).
// Ports: req_* request handshake; st_* store data and consume pulse; data_addr/dm_write_*/data_in_* to
//        datamem; data_out_* from datamem; ld_* tagged load return; beat_idx element index of bank 0; done.
module v_lsu_seq
  import v_lsu_seq_pkg::*;
#(
  parameter int DATAMEM_BITS = DEF_DATAMEM_BITS,
  parameter int VLMAX        = DEF_VLMAX,
  parameter int WIDTH        = DEF_DATAMEM_WIDTH
) (
  input  logic                    core_clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [DATAMEM_BITS-1:0] req_base,
  input  logic [VL_W-1:0]         req_vl,
  input  logic                    st_valid,
  input  logic [WIDTH-1:0]        st_data_0,
  input  logic [WIDTH-1:0]        st_data_1,
  input  logic [WIDTH-1:0]        st_data_2,
  input  logic [WIDTH-1:0]        st_data_3,
  output logic                    st_take,
  output logic signed [IDX_W-1:0] beat_idx,
  output logic [DATAMEM_BITS-1:0] data_addr,
  output logic [3:0]              dm_write_0,
  output logic [3:0]              dm_write_1,
  output logic [3:0]              dm_write_2,
  output logic [3:0]              dm_write_3,
  output logic [WIDTH-1:0]        data_in_0,
  output logic [WIDTH-1:0]        data_in_1,
  output logic [WIDTH-1:0]        data_in_2,
  output logic [WIDTH-1:0]        data_in_3,
  input  logic [WIDTH-1:0]        data_out_0,
  input  logic [WIDTH-1:0]        data_out_1,
  input  logic [WIDTH-1:0]        data_out_2,
  input  logic [WIDTH-1:0]        data_out_3,
  output logic                    ld_valid,
  output logic [NUM_BANKS-1:0]    ld_mask,
  output logic signed [IDX_W-1:0] ld_idx,
  output logic [WIDTH-1:0]        ld_data_0,
  output logic [WIDTH-1:0]        ld_data_1,
  output logic [WIDTH-1:0]        ld_data_2,
  output logic [WIDTH-1:0]        ld_data_3,
  output logic                    done
);

  localparam int ROW_W = DATAMEM_BITS - 3;

  lsu_state_e              state_q, state_d;
  logic [ROW_W-1:0]        row_q;
  logic                    region_q;
  logic [1:0]              off_q;
  logic [VL_W-1:0]         vl_q;
  logic                    store_q;
  logic [BEAT_W-1:0]       beat_q;
  logic                    ld_valid_q;
  logic [NUM_BANKS-1:0]    ld_mask_q;
  logic signed [IDX_W-1:0] ld_idx_q;

  logic                    accept;
  logic [VL_W-1:0]         vl_clamp;
  logic [BEAT_W-1:0]       num_beats;
  logic                    last_beat;
  logic                    in_run;
  logic                    issue;
  logic                    wr_en;
  logic [NUM_BANKS-1:0]    lane_mask;
  logic [ROW_W-1:0]        row_cur;

  v_lsu_seq_lanemask u_lanemask (
    .off  (off_q),
    .vl   (vl_q),
    .beat (beat_q),
    .mask (lane_mask)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;
  // Oversized counts are clamped so the beat counter can never run past a legal request.
  assign vl_clamp  = (req_vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : req_vl;
  assign num_beats = beat_count(off_q, vl_q);
  assign last_beat = (beat_q == num_beats - 1'b1);
  assign in_run    = (state_q == ST_RUN);
  assign issue     = in_run & (~store_q | st_valid);
  assign wr_en     = in_run & store_q & st_valid;
  assign done      = (state_q == ST_DRAIN);

  // Row arithmetic is ROW_W wide so it wraps inside the region; the region bit is never touched.
  assign row_cur   = row_q + ROW_W'(beat_q);
  assign data_addr = in_run ? {region_q, row_cur, 2'b00} : '0;
  // Element index at bank 0: lanes below the base offset come out negative on beat 0.
  assign beat_idx  = $signed({beat_q, 2'b00} - {5'd0, off_q});

  assign st_take    = wr_en;
  assign dm_write_0 = {4{wr_en & lane_mask[0]}};
  assign dm_write_1 = {4{wr_en & lane_mask[1]}};
  assign dm_write_2 = {4{wr_en & lane_mask[2]}};
  assign dm_write_3 = {4{wr_en & lane_mask[3]}};
  assign data_in_0  = st_data_0;
  assign data_in_1  = st_data_1;
  assign data_in_2  = st_data_2;
  assign data_in_3  = st_data_3;

  assign ld_valid  = ld_valid_q;
  assign ld_mask   = ld_mask_q;
  assign ld_idx    = ld_idx_q;
  assign ld_data_0 = data_out_0;
  assign ld_data_1 = data_out_1;
  assign ld_data_2 = data_out_2;
  assign ld_data_3 = data_out_3;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (vl_clamp != '0) ? ST_RUN : ST_DRAIN;
      ST_RUN:   if (issue && last_beat) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      region_q   <= 1'b0;
      off_q      <= '0;
      vl_q       <= '0;
      store_q    <= 1'b0;
      beat_q     <= '0;
      ld_valid_q <= 1'b0;
      ld_mask_q  <= '0;
      ld_idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        row_q    <= req_base[DATAMEM_BITS-2:ROW_LSB];
        region_q <= req_base[DATAMEM_BITS-1];
        off_q    <= req_base[BANK_MSB:BANK_LSB];
        vl_q     <= vl_clamp;
        store_q  <= req_store;
        beat_q   <= '0;
      end else if (issue) begin
        beat_q <= beat_q + 1'b1;
      end
      // Load return is tagged from the issue cycle to line up with datamem's one-cycle read.
      ld_valid_q <= issue & ~store_q;
      ld_mask_q  <= (issue & ~store_q) ? lane_mask : '0;
      ld_idx_q   <= beat_idx;
    end
  end

endmodule

// File: tb/tb_v_lsu_seq.sv
module tb_v_lsu_seq;

  logic        core_clk;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [13:0] req_base;
  logic [5:0]  req_vl;
  logic        st_valid, st_take;
  logic [31:0] st_data_0, st_data_1, st_data_2, st_data_3;
  logic [6:0]  beat_idx, ld_idx;
  logic [13:0] data_addr;
  logic [3:0]  dm_write_0, dm_write_1, dm_write_2, dm_write_3;
  logic [31:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic        ld_valid, done;
  logic [3:0]  ld_mask;
  logic [31:0] ld_data_0, ld_data_1, ld_data_2, ld_data_3;
  logic [15:0] dmw;

  int n_checks = 0;
  int n_fail   = 0;

  assign dmw = {dm_write_3, dm_write_2, dm_write_1, dm_write_0};

  v_lsu_seq dut (
    .core_clk(core_clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_base(req_base), .req_vl(req_vl),
    .st_valid(st_valid), .st_data_0(st_data_0), .st_data_1(st_data_1),
    .st_data_2(st_data_2), .st_data_3(st_data_3), .st_take(st_take),
    .beat_idx(beat_idx), .data_addr(data_addr),
    .dm_write_0(dm_write_0), .dm_write_1(dm_write_1),
    .dm_write_2(dm_write_2), .dm_write_3(dm_write_3),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .data_in_2(data_in_2), .data_in_3(data_in_3),
    .data_out_0(data_out_0), .data_out_1(data_out_1),
    .data_out_2(data_out_2), .data_out_3(data_out_3),
    .ld_valid(ld_valid), .ld_mask(ld_mask), .ld_idx(ld_idx),
    .ld_data_0(ld_data_0), .ld_data_1(ld_data_1),
    .ld_data_2(ld_data_2), .ld_data_3(ld_data_3),
    .done(done)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  // Datamem read model: word = {A, bank, 10'b0, addr}, one cycle after the address.
  function automatic logic [31:0] mem_word(input logic [13:0] a, input int b);
    return {4'hA, 4'(b), 10'd0, a};
  endfunction

  always @(posedge core_clk) begin
    data_out_0 <= mem_word(data_addr, 0);
    data_out_1 <= mem_word(data_addr, 1);
    data_out_2 <= mem_word(data_addr, 2);
    data_out_3 <= mem_word(data_addr, 3);
  end

  task automatic step();
    @(posedge core_clk);
    @(negedge core_clk);
  endtask

  // Offers a request for one cycle; returns at the negedge of the first post-accept cycle.
  task automatic send(input logic s, input logic [13:0] b, input logic [5:0] v);
    req_valid = 1'b1; req_store = s; req_base = b; req_vl = v;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_store = 1'b0; req_base = 14'h0040; req_vl = 6'd4;
    @(negedge core_clk); #1;
    n_checks++;
    if ({req_ready, dmw, st_take, ld_valid, ld_mask, done} !== {1'b1, 16'h0, 1'b0, 1'b0, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b dmw=%h take=%b ldv=%b mask=%h done=%b, expected rdy=1 rest 0",
               req_ready, dmw, st_take, ld_valid, ld_mask, done);
    end
    n_checks++;
    if (data_addr !== 14'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", data_addr); end
    step();
    rst = 1'b0; req_valid = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || data_addr !== 14'h0) begin
      n_fail++; $display("FAIL reset_req_ignored: got rdy=%b addr=%h expected rdy=1 addr=0000", req_ready, data_addr);
    end
    step();
  endtask

  task automatic test_load_aligned();
    send(1'b0, 14'h0040, 6'd8);
    #1;
    n_checks++;
    if (data_addr !== 14'h0040 || dmw !== 16'h0 || beat_idx !== 7'd0 || req_ready !== 1'b0 || ld_valid !== 1'b0) begin
      n_fail++; $display("FAIL ld8_beat0: got addr=%h dmw=%h idx=%h rdy=%b ldv=%b expected 0040 0000 00 0 0",
                         data_addr, dmw, beat_idx, req_ready, ld_valid);
    end
    step(); #1;
    n_checks++;
    if (data_addr !== 14'h0044 || beat_idx !== 7'd4 || ld_valid !== 1'b1 || ld_mask !== 4'hF || ld_idx !== 7'd0 || done !== 1'b0) begin
      n_fail++; $display("FAIL ld8_beat1: got addr=%h idx=%h ldv=%b mask=%h ldidx=%h done=%b expected 0044 04 1 f 00 0",
                         data_addr, beat_idx, ld_valid, ld_mask, ld_idx, done);
    end
    n_checks++;
    if (ld_data_0 !== 32'hA0000040) begin n_fail++; $display("FAIL ld8_data0: got %h expected a0000040", ld_data_0); end
    step(); #1;
    n_checks++;
    if (done !== 1'b1 || ld_valid !== 1'b1 || ld_mask !== 4'hF || ld_idx !== 7'd4 || data_addr !== 14'h0) begin
      n_fail++; $display("FAIL ld8_drain: got done=%b ldv=%b mask=%h ldidx=%h addr=%h expected 1 1 f 04 0000",
                         done, ld_valid, ld_mask, ld_idx, data_addr);
    end
    n_checks++;
    if (ld_data_2 !== 32'hA2000044) begin n_fail++; $display("FAIL ld8_data2: got %h expected a2000044", ld_data_2); end
    step(); #1;
    n_checks++;
    if (done !== 1'b0 || ld_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ld8_idle: got done=%b ldv=%b rdy=%b expected 0 0 1", done, ld_valid, req_ready);
    end
  endtask

  task automatic test_load_offset();
    send(1'b0, 14'h0042, 6'd5);
    #1;
    n_checks++;
    if (data_addr !== 14'h0040 || beat_idx !== 7'h7E) begin
      n_fail++; $display("FAIL off2_beat0: got addr=%h idx=%h expected 0040 7e", data_addr, beat_idx);
    end
    step(); #1;
    n_checks++;
    if (data_addr !== 14'h0044 || ld_valid !== 1'b1 || ld_mask !== 4'b1100 || ld_idx !== 7'h7E) begin
      n_fail++; $display("FAIL off2_ret0: got addr=%h ldv=%b mask=%b ldidx=%h expected 0044 1 1100 7e",
                         data_addr, ld_valid, ld_mask, ld_idx);
    end
    n_checks++;
    if (ld_data_3 !== 32'hA3000040) begin n_fail++; $display("FAIL off2_data3: got %h expected a3000040", ld_data_3); end
    step(); #1;
    n_checks++;
    if (done !== 1'b1 || ld_valid !== 1'b1 || ld_mask !== 4'b0111 || ld_idx !== 7'd2) begin
      n_fail++; $display("FAIL off2_ret1: got done=%b ldv=%b mask=%b ldidx=%h expected 1 1 0111 02",
                         done, ld_valid, ld_mask, ld_idx);
    end
    step();
  endtask

  task automatic test_store_single();
    st_valid = 1'b1;
    st_data_0 = 32'hCAFE0000; st_data_1 = 32'hCAFE0001; st_data_2 = 32'hCAFE0002; st_data_3 = 32'hCAFE0003;
    send(1'b1, 14'h0003, 6'd1);
    #1;
    n_checks++;
    if (dmw !== 16'hF000 || st_take !== 1'b1 || data_addr !== 14'h0 || beat_idx !== 7'h7D) begin
      n_fail++; $display("FAIL st1_beat: got dmw=%h take=%b addr=%h idx=%h expected f000 1 0000 7d",
                         dmw, st_take, data_addr, beat_idx);
    end
    n_checks++;
    if (data_in_3 !== 32'hCAFE0003) begin n_fail++; $display("FAIL st1_data3: got %h expected cafe0003", data_in_3); end
    step(); #1;
    n_checks++;
    if (done !== 1'b1 || dmw !== 16'h0 || st_take !== 1'b0 || ld_valid !== 1'b0) begin
      n_fail++; $display("FAIL st1_done: got done=%b dmw=%h take=%b ldv=%b expected 1 0000 0 0", done, dmw, st_take, ld_valid);
    end
    step();
  endtask

  task automatic test_store_stall();
    int take_cnt = 0;
    send(1'b1, 14'h0000, 6'd12);
    for (int c = 1; c <= 6; c++) begin
      st_valid = !(c == 2 || c == 3);
      #1;
      if (st_take === 1'b1) take_cnt++;
      if (c == 1 || c == 4 || c == 5) begin
        n_checks++;
        if (dmw !== 16'hFFFF || st_take !== 1'b1 || data_addr !== 14'((c == 1) ? 0 : 4 * (c - 3))) begin
          n_fail++; $display("FAIL stall_issue c%0d: got dmw=%h take=%b addr=%h", c, dmw, st_take, data_addr);
        end
      end
      if (c == 2 || c == 3) begin
        n_checks++;
        if (dmw !== 16'h0 || st_take !== 1'b0 || data_addr !== 14'h0004) begin
          n_fail++; $display("FAIL stall_hold c%0d: got dmw=%h take=%b addr=%h expected 0000 0 0004", c, dmw, st_take, data_addr);
        end
      end
      n_checks++;
      if (done !== (c == 6)) begin
        n_fail++; $display("FAIL stall_done c%0d: got %b expected %b", c, done, (c == 6));
      end
      step();
    end
    n_checks++;
    if (take_cnt != 3) begin n_fail++; $display("FAIL stall_takes: got %0d expected 3", take_cnt); end
    st_valid = 1'b0;
  endtask

  task automatic test_load_wrap();
    send(1'b0, 14'h1FFC, 6'd8);
    #1;
    n_checks++;
    if (data_addr !== 14'h1FFC) begin n_fail++; $display("FAIL wrap0_beat0: got %h expected 1ffc", data_addr); end
    step(); #1;
    n_checks++;
    if (data_addr !== 14'h0000 || ld_mask !== 4'hF) begin
      n_fail++; $display("FAIL wrap0_beat1: got addr=%h mask=%h expected 0000 f", data_addr, ld_mask);
    end
    step(); step();
    send(1'b0, 14'h3FFC, 6'd8);
    step(); #1;
    n_checks++;
    if (data_addr !== 14'h2000) begin n_fail++; $display("FAIL wrap1_beat1: got %h expected 2000", data_addr); end
    step(); step();
  endtask

  task automatic test_vl_zero();
    send(1'b0, 14'h0040, 6'd0);
    #1;
    n_checks++;
    if (done !== 1'b1 || dmw !== 16'h0 || ld_valid !== 1'b0 || data_addr !== 14'h0 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL vl0_done: got done=%b dmw=%h ldv=%b addr=%h rdy=%b expected 1 0000 0 0000 0",
                         done, dmw, ld_valid, data_addr, req_ready);
    end
    step(); #1;
    n_checks++;
    if (done !== 1'b0 || ld_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL vl0_idle: got done=%b ldv=%b rdy=%b expected 0 0 1", done, ld_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    st_valid = 1'b1;
    send(1'b1, 14'h0000, 6'd16);
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if (dmw !== 16'hFFFF || data_addr !== 14'h0004) begin
      n_fail++; $display("FAIL rstmid_beat1: got dmw=%h addr=%h expected ffff 0004", dmw, data_addr);
    end
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (dmw !== 16'h0 || req_ready !== 1'b1 || done !== 1'b0 || st_take !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: got dmw=%h rdy=%b done=%b take=%b expected 0000 1 0 0", dmw, req_ready, done, st_take);
    end
    for (int c = 0; c < 5; c++) begin
      if (done === 1'b1 || ld_valid === 1'b1 || dmw !== 16'h0) seen++;
      step(); #1;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", seen); end
    st_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_base = '0; req_vl = '0;
    st_valid = 1'b0; st_data_0 = '0; st_data_1 = '0; st_data_2 = '0; st_data_3 = '0;
    test_reset();
    test_load_aligned();
    test_load_offset();
    test_store_single();
    test_store_stall();
    test_load_wrap();
    test_vl_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/v_lsu_seq.md
# v_lsu_seq

Vector unit-stride load/store sequencer for the four-bank vector data memory (`v_datamem`). It accepts one vector memory request at a time: a word base address, an element count and a direction. It then issues one bank-parallel beat per cycle on the datamem core port, driving the shared row address and the per-bank byte write enables. For loads it tags the one-cycle-late bank read data with element indices. It sits between the vector coprocessor issue logic and `v_datamem`, and is the only master of the datamem core port.

## Interface
Parameters:
- `DATAMEM_BITS`, 14, datamem address width; bit 13 = region, [12:2] = row, [1:0] = bank
- `VLMAX`, 32, maximum elements per request
- `WIDTH`, 32, element/bank width

Ports:
- `core_clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request offered
- `req_ready`  out  1  high only in IDLE
- `req_store`  in  1  1 = store, 0 = load
- `req_base`  in  DATAMEM_BITS  word base address (bank = [1:0])
- `req_vl`  in  6  element count, 0..VLMAX
- `st_valid`  in  1  store data for current beat present
- `st_data_0..3`  in  WIDTH each  bank-b element st_idx+b
- `st_take`  out  1  store beat issued this cycle; st_data consumed
- `beat_idx`  out  7 signed  element index at bank 0 of current beat (= st_idx)
- `data_addr`  out  DATAMEM_BITS  to datamem; [1:0] always 0
- `dm_write_0..3`  out  4 each  byte enables per bank (all-ones or zero)
- `data_in_0..3`  out  WIDTH each  = st_data_0..3
- `data_out_0..3`  in  WIDTH each  datamem read data, 1-cycle latency
- `ld_valid`  out  1  load beat returned
- `ld_mask`  out  4  lanes holding real elements
- `ld_idx`  out  7 signed  element index at lane 0
- `ld_data_0..3`  out  WIDTH each  = data_out_0..3
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN.
- **IDLE**
  - `req_valid & req_ready` latches base row R, bank offset off = base[1:0], region bit, vl and dir; beat counter j = 0.
  - Goes to RUN if vl>0, else DRAIN.
- **RUN**
  - Beat count B = ceil((off+vl)/4). Beat j drives:
    - `data_addr` = {region, (R+j) mod 2048, 2'b00}; the row wraps within its region and the region bit is never altered.
    - `beat_idx` = 4j − off.
  - Bank b is active iff off ≤ 4j+b < off+vl.
  - Load beat: issues every cycle, with all `dm_write` = 0.
  - Store beat: issues only when `st_valid`. It then sets `dm_write_b` = 4'hF for each active bank and pulses `st_take`. When `st_valid` = 0 the beat stalls with all write enables 0 and address held.
  - After beat B−1 issues, go to DRAIN.
- **Load return**
  - Registered from the issue cycle: `ld_valid`, `ld_mask` = active banks, `ld_idx` = beat_idx.
  - `ld_data_b` is a combinational pass of `data_out_b`.
- **DRAIN**: one cycle; `done` = 1; the last `ld_valid` coincides with it for loads. Then IDLE.
- Index arithmetic is 7-bit signed. Beat-0 lanes below off carry negative indices and are always masked.

## Timing
- Reset values: IDLE; `req_ready` = 1; `dm_write_*` = 0; `data_addr` = 0; `st_take` = 0; `ld_valid` = 0; `ld_mask` = 0; `done` = 0.
- Accept-to-first-beat: 1 cycle.
- Throughput: 1 beat/cycle, less store stalls.
- Load data latency: beat issue + 1.
- Request completion: `done` = 1 cycle after last beat issue. For vl = 0, `done` = 1 cycle after accept.
- `req_ready` is low from the accept cycle until the cycle after `done`. Back-to-back requests are therefore spaced at least 1 idle cycle apart.
- Reset mid-request: abandons the request and drops write enables in the same clock edge. No `done` or `ld_valid` is produced afterwards.
- A `req_valid` offered in the reset cycle is ignored.

## Structure
- `v_lsu_seq.vh` (or `constants.vh`) holds:
  - state encodings
  - `VLMAX`, `DATAMEM_BITS`, `DATAMEM_WIDTH`
  - row and bank field positions
- A sub-module `v_lsu_lanemask` is natural: combinational active-bank mask from (off, vl, j).
- Everything else stays in one module.

## Test plan
- Load base 0x0040, vl = 8:
  - beats at rows 0x010 and 0x011, masks F, F, `done` on cycle 3;
  - `ld_idx` 0 then 4, each 1 cycle after issue.
- Load base 0x0042 (off = 2), vl = 5:
  - B = 2; beat 0 mask 4'b1100 with `ld_idx` −2; beat 1 mask 4'b0111 with `ld_idx` 2.
- Store base 0x0003, vl = 1:
  - single beat, `dm_write_3` = F and others 0, `data_in_3` = `st_data_3`, `done` next cycle.
- Store base 0x0000, vl = 12 with `st_valid` low for 2 cycles at beat 1:
  - address held at row 1 and writes 0 during the stall;
  - 3 `st_take` pulses total; `done` 6 cycles after accept.
- Load base 0x1FFC (row 0x7FF), vl = 8:
  - second beat `data_addr` = 0x0000, so the row wraps and region bit 13 is unchanged;
  - vl = 0 request: `done` 1 cycle after accept, no beats issued.
- Assert `rst` during beat 1 of a 4-beat store:
  - `dm_write` = 0 and IDLE from the next edge, `req_ready` = 1, no `done`.
